// File: rtl/main_mem_pkg.sv
// Shared types and helpers for the line-oriented main-memory model.
// Optional byte-strobe writes are enabled with the MAIN_MEM_BYTE_WRITE_EN macro.
package main_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

    // Default-configuration line geometry, shared with anything sized for the standard build.
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int LINE_BITS      = DEF_LINE_WORDS * DEF_DATA_W;
    localparam int BE_BITS        = LINE_BITS / 8;

    // log2 of a power of two; returns 0 for a single-word line.
    function automatic int line_idx_w(input int line_words);
        int w;
        w = 0;
        while ((1 << w) < line_words) w++;
        return w;
    endfunction

endpackage

// File: rtl/main_mem_array.sv
// Word-organised storage with a line-wide read port and a byte-masked line write port.
// Byte masking is always present here; the top drives all-ones strobes when MAIN_MEM_BYTE_WRITE_EN is undefined.
module main_mem_array
    import main_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                               clk,
    input  logic                               wr_en,
    input  logic [ADDR_W-1:0]                  line_addr,
    input  logic [LINE_WORDS*DATA_W-1:0]       wdata,
    input  logic [LINE_WORDS*DATA_W/8-1:0]     be,
    output logic [LINE_WORDS*DATA_W-1:0]       rdata
);

    localparam int IDX_W = line_idx_w(LINE_WORDS);
    localparam int BPW   = DATA_W / 8;
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'((1 << IDX_W) - 1);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [ADDR_W-1:0] base_addr;

    // Word i of a line always sits at {line bits, i}; the line never wraps.
    assign base_addr = line_addr & ~IDX_MASK;

    always_comb begin
        rdata = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            rdata[i*DATA_W +: DATA_W] = mem[base_addr | ADDR_W'(i)];
        end
    end

    // NOTE: the storage array has no reset; only control state is reset, so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                for (int b = 0; b < BPW; b++) begin
                    if (be[i*BPW + b]) begin
                        mem[base_addr | ADDR_W'(i)][b*8 +: 8] <= wdata[i*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/main_mem_line.sv
// Line-oriented main memory: valid/ready request/response, fixed access latency, one request in flight.
// Define MAIN_MEM_BYTE_WRITE_EN to add the req_be byte-strobe port; otherwise writes replace the full line.
module main_mem_line
    import main_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 5
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic                               req_we,
    input  logic [ADDR_W-1:0]                  req_addr,
    input  logic [LINE_WORDS*DATA_W-1:0]       req_wdata,
`ifdef MAIN_MEM_BYTE_WRITE_EN
    input  logic [LINE_WORDS*DATA_W/8-1:0]     req_be,
`endif
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic                               rsp_we,
    output logic [LINE_WORDS*DATA_W-1:0]       rsp_rdata
);

    localparam int LINE_W = LINE_WORDS * DATA_W;
    localparam int BE_W   = LINE_W / 8;
    localparam int CNT_W  = $clog2(LATENCY) + 1;

    mem_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic [BE_W-1:0]    be_q, be_d;
    logic               rsp_we_q, rsp_we_d;
    logic [LINE_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [BE_W-1:0]    be_in;
    logic [LINE_W-1:0]  rd_line;
    logic               commit;

`ifdef MAIN_MEM_BYTE_WRITE_EN
    assign be_in = req_be;
`else
    assign be_in = '1;
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        commit      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = be_in;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    commit      = 1'b1;
                    rsp_we_d    = we_q;
                    rsp_rdata_d = we_q ? '0 : rd_line;
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Handshake outputs are pure state decodes: no path from req_valid or rsp_ready.
    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;

    main_mem_array #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS)
    ) u_array (
        .clk       (clk),
        .wr_en     (commit && we_q),
        .line_addr (addr_q),
        .wdata     (wdata_q),
        .be        (be_q),
        .rdata     (rd_line)
    );

endmodule

// File: tb/tb_main_mem_line.sv
// Self-checking bench for main_mem_line: directed handshake/reset cases plus random line traffic
// compared against an associative-array memory model. Honours MAIN_MEM_BYTE_WRITE_EN if defined.
module tb_main_mem_line;
    import main_mem_pkg::*;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 16;
    localparam int LINE_WORDS = 4;
    localparam int LATENCY    = 5;
    localparam int LW         = LINE_WORDS * DATA_W;
    localparam int BW         = LW / 8;
    localparam int BOUND      = 100;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LW-1:0]     req_wdata = '0;
    logic [BW-1:0]     req_be = '1;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_we;
    logic [LW-1:0]     rsp_rdata;

    int n_pass = 0;
    int n_total = 0;

    logic [DATA_W-1:0] model [int];

    always #5 clk = ~clk;

    main_mem_line #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .LATENCY(LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef MAIN_MEM_BYTE_WRITE_EN
        .req_be    (req_be),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata)
    );

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [BW-1:0] eff_be(input logic [BW-1:0] be);
`ifdef MAIN_MEM_BYTE_WRITE_EN
        return be;
`else
        return '1;
`endif
    endfunction

    function automatic int line_base(input logic [ADDR_W-1:0] a);
        return (int'(a) / LINE_WORDS) * LINE_WORDS;
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [LW-1:0] d, input logic [BW-1:0] be);
        logic [DATA_W-1:0] w;
        for (int i = 0; i < LINE_WORDS; i++) begin
            w = model.exists(line_base(a) + i) ? model[line_base(a) + i] : 'x;
            for (int b = 0; b < DATA_W/8; b++)
                if (be[i*(DATA_W/8) + b]) w[b*8 +: 8] = d[i*DATA_W + b*8 +: 8];
            model[line_base(a) + i] = w;
        end
    endtask

    function automatic logic [LW-1:0] model_read(input logic [ADDR_W-1:0] a);
        logic [LW-1:0] l;
        for (int i = 0; i < LINE_WORDS; i++)
            l[i*DATA_W +: DATA_W] = model.exists(line_base(a) + i) ? model[line_base(a) + i] : 'x;
        return l;
    endfunction

    // Present a request and return once the accepting edge has passed.
    task automatic send_req(input logic we, input logic [ADDR_W-1:0] a, input logic [LW-1:0] d,
                            input logic [BW-1:0] be);
        int n;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; req_be = be; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Count edges from accept until rsp_valid appears.
    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!rsp_valid && lat < BOUND);
        if (!rsp_valid) check("rsp_timeout", 0, 1);
    endtask

    task automatic handshake(input int delay);
        repeat (delay) @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("post_hs_rsp_valid", LW'(rsp_valid), 0);
        check("post_hs_req_ready", LW'(req_ready), 1);
    endtask

    // Full transaction checked against the model.
    task automatic txn(input string tag, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [LW-1:0] d, input logic [BW-1:0] be, input int delay);
        int lat;
        logic [LW-1:0] exp;
        send_req(we, a, d, be);
        exp = we ? '0 : model_read(a);
        wait_rsp(lat);
        check({tag, "_latency"}, LW'(lat), LW'(LATENCY));
        check({tag, "_rsp_we"}, LW'(rsp_we), LW'(we));
        check({tag, "_rdata"}, rsp_rdata, exp);
        if (we) model_write(a, d, eff_be(be));
        handshake(delay);
    endtask

    initial begin
        logic [LW-1:0] line;
        logic [LW-1:0] held;
        logic [LW-1:0] exp_byte;
        int lat;
        int seen;

        // Reset state, then release.
        repeat (3) @(posedge clk);
        #1 check("rst_req_ready", LW'(req_ready), 1);
        check("rst_rsp_valid", LW'(rsp_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("rel_req_ready", LW'(req_ready), 1);
        check("rel_rsp_valid", LW'(rsp_valid), 0);
        check("rel_rsp_rdata", rsp_rdata, 0);

        // Write then read back with unaligned address.
        line = 128'h44443333_22221111_DDDDCCCC_BBBBAAAA;
        txn("wr10", 1'b1, 16'h0010, line, '1, 0);
        txn("rd13", 1'b0, 16'h0013, '0, '1, 0);

        // Backpressure with a competing request offered during RESP.
        send_req(1'b0, 16'h0013, '0, '1);
        wait_rsp(lat);
        check("bp_latency", LW'(lat), LW'(LATENCY));
        held = rsp_rdata;
        check("bp_rdata", held, line);
        @(negedge clk);
        req_we = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0)
                check("bp_hold", {rsp_valid, req_ready, rsp_rdata[LW-3:0]},
                      {1'b1, 1'b0, held[LW-3:0]});
        end
        check("bp_hold_valid", LW'(rsp_valid), 1);
        check("bp_hold_ready", LW'(req_ready), 0);
        @(negedge clk) rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp_R_req_ready", LW'(req_ready), 1);
        check("bp_R_rsp_valid", LW'(rsp_valid), 0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("bp_R1_accepted", LW'(req_ready), 0);
        wait_rsp(lat);
        check("bp2_latency", LW'(lat), LW'(LATENCY));
        check("bp2_rdata", rsp_rdata, line);
        handshake(0);

        // Reset mid-write: uncommitted data must be discarded.
        txn("zero20", 1'b1, 16'h0020, '0, '1, 0);
        send_req(1'b1, 16'h0020, '1, '1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 check("midrst_req_ready", LW'(req_ready), 1);
        check("midrst_rsp_valid", LW'(rsp_valid), 0);
        @(negedge clk) rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2*LATENCY; i++) begin
            @(posedge clk);
            #1 if (rsp_valid) seen++;
        end
        check("midrst_no_rsp", LW'(seen), 0);
        txn("rd20", 1'b0, 16'h0020, '0, '1, 1);

        // Byte strobe write over a zeroed line.
        txn("zero30", 1'b1, 16'h0030, '0, '1, 0);
        txn("be30", 1'b1, 16'h0030, '1, BW'(1), 0);
`ifdef MAIN_MEM_BYTE_WRITE_EN
        exp_byte = LW'(8'hFF);
`else
        exp_byte = '1;
`endif
        send_req(1'b0, 16'h0031, '0, '1);
        wait_rsp(lat);
        check("be30_readback", rsp_rdata, exp_byte);
        handshake(0);

        // Random traffic over 16 pre-initialised lines.
        for (int l = 0; l < 16; l++)
            txn("init", 1'b1, ADDR_W'(16'h0040 + l*LINE_WORDS),
                {$urandom, $urandom, $urandom, $urandom}, '1, 0);
        for (int k = 0; k < 40; k++) begin
            txn("rand", 1'($urandom_range(0, 1)), ADDR_W'(16'h0040 + $urandom_range(0, 63)),
                {$urandom, $urandom, $urandom, $urandom}, BW'($urandom), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
